// File: rtl/mul_issue_controller.sv
// Issue/retire controller for an external pipelined unsigned array multiplier.
// Conditions signed operands to magnitudes and restores the sign at retire.
module mul_issue_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int PIPELINE_DEPTH = 4,
    parameter int TAG_WIDTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [1:0]              req_op_i,
    input  logic [DATA_WIDTH-1:0]   req_a_i,
    input  logic [DATA_WIDTH-1:0]   req_b_i,
    input  logic [TAG_WIDTH-1:0]    req_tag_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,
    output logic [TAG_WIDTH-1:0]    rsp_tag_o,
    output logic                    mul_clk_en_o,
    output logic                    mul_valid_o,
    output logic [DATA_WIDTH-1:0]   mul_multiplicand_o,
    output logic [DATA_WIDTH-1:0]   mul_multiplier_o,
    input  logic [2*DATA_WIDTH-1:0] mul_product_i,
    output logic                    busy_o
);

    localparam int W  = DATA_WIDTH;
    localparam int SD = PIPELINE_DEPTH - 1;
    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b11;

    typedef struct packed {
        logic                 vld;
        logic [1:0]           op;
        logic                 neg;
        logic [TAG_WIDTH-1:0] tag;
    } side_t;

    side_t                side_q [SD];
    logic                 rsp_vld_q;
    logic [W-1:0]         res_q;
    logic [TAG_WIDTH-1:0] tag_q;

    logic         a_sgn;
    logic         b_sgn;
    logic         a_neg;
    logic         b_neg;
    logic         adv;
    logic         accept;
    logic         any_vld;
    logic [2*W-1:0] prod;

    // MUL shares MULH sign handling; the low half is sign-agnostic anyway
    always_comb begin
        a_sgn = (req_op_i != OP_MULHU);
        b_sgn = (req_op_i[1] == 1'b0);
        a_neg = a_sgn & req_a_i[W-1];
        b_neg = b_sgn & req_b_i[W-1];
    end

    assign adv          = !rsp_vld_q || rsp_ready_i;
    assign mul_clk_en_o = adv;
    assign req_ready_o  = adv && !flush_i;
    assign accept       = req_valid_i && req_ready_o;
    assign mul_valid_o  = accept;

    assign mul_multiplicand_o = a_neg ? -req_a_i : req_a_i;
    assign mul_multiplier_o   = b_neg ? -req_b_i : req_b_i;

    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < SD; i++)
            any_vld = any_vld | side_q[i].vld;
    end

    assign prod = side_q[SD-1].neg ? -mul_product_i : mul_product_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < SD; i++)
                side_q[i] <= '0;
            rsp_vld_q <= 1'b0;
            res_q     <= '0;
            tag_q     <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < SD; i++)
                side_q[i].vld <= 1'b0;
            rsp_vld_q <= 1'b0;
        end else if (adv) begin
            side_q[0] <= '{vld: accept,
                           op:  req_op_i,
                           neg: a_neg ^ b_neg,
                           tag: req_tag_i};
            for (int i = 1; i < SD; i++)
                side_q[i] <= side_q[i-1];
            if (side_q[SD-1].vld) begin
                rsp_vld_q <= 1'b1;
                tag_q     <= side_q[SD-1].tag;
                if (side_q[SD-1].op == OP_MUL)
                    res_q <= prod[W-1:0];
                else
                    res_q <= prod[2*W-1:W];
            end else begin
                rsp_vld_q <= 1'b0;
            end
        end
    end

    assign rsp_valid_o = rsp_vld_q;
    assign rsp_data_o  = res_q;
    assign rsp_tag_o   = tag_q;
    assign busy_o      = rsp_vld_q | any_vld;

endmodule

// File: tb/tb_mul_issue_controller.sv
// Bench for mul_issue_controller: directed vectors, stall/flush/reset
// sequences and randomized traffic against a signed-arithmetic scoreboard.
module tb_mul_issue_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_tag = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        mul_clk_en;
    logic        mul_valid;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [63:0] mprod;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int nrsp  = 0;

    always #5 clk = ~clk;

    mul_issue_controller dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .flush_i            (flush),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_op_i           (req_op),
        .req_a_i            (req_a),
        .req_b_i            (req_b),
        .req_tag_i          (req_tag),
        .rsp_valid_o        (rsp_valid),
        .rsp_ready_i        (rsp_ready),
        .rsp_data_o         (rsp_data),
        .rsp_tag_o          (rsp_tag),
        .mul_clk_en_o       (mul_clk_en),
        .mul_valid_o        (mul_valid),
        .mul_multiplicand_o (mcand),
        .mul_multiplier_o   (mplier),
        .mul_product_i      (mprod),
        .busy_o             (busy)
    );

    // 4-stage multiplier: combinational product captured, then 3 registers
    logic [63:0] pipe [3];
    always @(posedge clk) begin
        if (mul_clk_en) begin
            pipe[0] <= {32'b0, mcand} * {32'b0, mplier};
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
    end
    assign mprod = pipe[2];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(logic [1:0] op,
                                            logic [31:0] a,
                                            logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op != 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
    } exp_t;
    exp_t q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                chk("sb_have", q.size() != 0, 1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_data", rsp_data, e.d);
                    chk("sb_tag", rsp_tag, e.t);
                end
                nrsp++;
            end
            if (flush)
                q.delete();
            if (req_valid && req_ready)
                q.push_back('{d: ref_res(req_op, req_a, req_b),
                              t: req_tag});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [1:0] op, logic [31:0] a,
                         logic [31:0] b, logic [3:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
    endtask

    task automatic run_vec(string name, logic [1:0] op, logic [31:0] a,
                           logic [31:0] b, logic [3:0] tag,
                           logic [31:0] exp);
        int n;
        cyc();
        drive(op, a, b, tag);
        #1;
        chk({name, "_ready"}, req_ready, 1);
        cyc();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            cyc();
            n++;
        end
        chk({name, "_lat"}, n, 4);
        chk({name, "_data"}, rsp_data, exp);
        chk({name, "_tag"}, rsp_tag, tag);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [8];

    initial begin
        int idx, stall, base, n;
        logic seen;
        logic [31:0] hold_d;
        logic [3:0]  hold_t;

        vt[0] = '{2'b00, 32'd7,        32'hFFFFFFFD, 4'd3,  32'hFFFFFFEB};
        vt[1] = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'd4,  32'h3FFFFFFF};
        vt[2] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5,  32'h00000000};
        vt[3] = '{2'b10, 32'h80000000, 32'd2,        4'd6,  32'hFFFFFFFF};
        vt[4] = '{2'b11, 32'h80000000, 32'd2,        4'd7,  32'h00000001};
        vt[5] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd8,  32'h00000001};
        vt[6] = '{2'b00, 32'd0,        32'hDEADBEEF, 4'd9,  32'h00000000};
        vt[7] = '{2'b10, 32'd5,        32'hFFFFFFFF, 4'd10, 32'h00000004};

        #12;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clk_en", mul_clk_en, 1);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_data", rsp_data, 0);
        chk("rst_tag", rsp_tag, 0);
        cyc();
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_vec($sformatf("vec%0d", i), vt[i].op, vt[i].a,
                    vt[i].b, vt[i].tag, vt[i].exp);

        // three back-to-back high-half ops
        cyc(); drive(2'b01, 32'h80000000, 32'h80000000, 4'd1);
        cyc(); drive(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2);
        cyc(); drive(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3);
        cyc(); req_valid = 1'b0;
        cyc();
        chk("b2b_v0", rsp_valid, 1);
        chk("b2b_d0", rsp_data, 32'h40000000);
        cyc();
        chk("b2b_v1", rsp_valid, 1);
        chk("b2b_d1", rsp_data, 32'hFFFFFFFE);
        cyc();
        chk("b2b_v2", rsp_valid, 1);
        chk("b2b_d2", rsp_data, 32'hFFFFFFFF);
        chk("b2b_t2", rsp_tag, 3);

        // six requests with a 5-cycle response stall
        cyc();
        idx = 0; stall = 0; seen = 1'b0; base = nrsp;
        hold_d = '0; hold_t = '0;
        for (int c = 0; c < 40 && (nrsp - base) < 6; c++) begin
            req_valid = (idx < 6);
            req_op    = 2'b00;
            req_a     = 32'(idx + 100);
            req_b     = 32'hFFFFFFF0;
            req_tag   = 4'(idx);
            if (rsp_valid && !seen) begin
                seen = 1'b1;
                hold_d = rsp_data;
                hold_t = rsp_tag;
            end
            rsp_ready = !(seen && stall < 5);
            #1;
            if (!rsp_ready) begin
                chk("stall_clk_en", mul_clk_en, 0);
                chk("stall_req_ready", req_ready, 0);
                chk("stall_hold_d", rsp_data, hold_d);
                chk("stall_hold_t", rsp_tag, hold_t);
                stall++;
            end
            if (req_valid && req_ready)
                idx++;
            cyc();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("stall_sent", idx, 6);
        chk("stall_rcvd", nrsp - base, 6);

        // flush kills tags 1,2; tag 7 follows
        cyc(); drive(2'b00, 32'd11, 32'd12, 4'd1);
        cyc(); drive(2'b00, 32'd13, 32'd14, 4'd2);
        cyc(); req_valid = 1'b0;
        cyc(); flush = 1'b1;
        #1;
        chk("flush_req_ready", req_ready, 0);
        cyc(); flush = 1'b0;
        drive(2'b00, 32'd6, 32'd7, 4'd7);
        #1;
        chk("flush_busy", busy, 0);
        chk("flush_valid", rsp_valid, 0);
        cyc(); req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            cyc();
            n++;
        end
        chk("flush_lat", n, 4);
        chk("flush_tag", rsp_tag, 7);
        chk("flush_data", rsp_data, 42);

        // reset with ops in flight and a response pending
        for (int k = 0; k < 5; k++) begin
            cyc();
            drive(2'b00, 32'(k + 1), 32'd9, 4'(k + 8));
        end
        #1;
        chk("rst2_pre_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst2_valid", rsp_valid, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_data", rsp_data, 0);
        chk("rst2_tag", rsp_tag, 0);
        chk("rst2_clk_en", mul_clk_en, 1);
        chk("rst2_ready", req_ready, 1);
        req_valid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        run_vec("rst2_mulhu", 2'b11, 32'd2, 32'd3, 4'd1, 32'd0);
        run_vec("rst2_mul", 2'b00, 32'd2, 32'd3, 4'd2, 32'd6);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            cyc();
            req_valid = ($urandom % 4) != 0;
            req_op    = 2'($urandom);
            case ($urandom % 4)
                0: req_a = 32'h80000000;
                1: req_a = 32'hFFFFFFFF;
                default: req_a = $urandom;
            endcase
            case ($urandom % 4)
                0: req_b = 32'h80000000;
                1: req_b = 32'd0;
                default: req_b = $urandom;
            endcase
            req_tag   = 4'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 60) == 0;
        end
        cyc();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        flush     = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            cyc();
            n++;
        end
        cyc();
        chk("drain_busy", busy, 0);
        chk("drain_q", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
